imem_port_arbiter: RTL

- Shares the single-port synchronous core memory between two requesters: the fetch stage (instruction reads) and the load/store unit (data reads/writes).
- Grants one requester per cycle and tracks which requester owns the one-cycle-delayed read response.
- Generates the fetch stall that holds PC when fetch loses arbitration.
- Squashes an in-flight fetch response when a PC redirect occurs.

---
 rtl/imem_port_arbiter_pkg.sv | 13 +
 rtl/imem_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the core memory port arbiter: address width and
// response-owner encoding used by the arbiter and anything that decodes it.
package imem_port_arbiter_pkg;

  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LSU   = 2'd2
  } resp_own_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// LSU: per-cycle grant, fetch anti-starvation, response demux and fetch squash.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store side
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  // memory side
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  resp_own_e         resp_own_q, resp_own_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       ls_rdata_q;
  logic              starved;

  assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Grant: LSU has priority except when fetch has been starved long enough.
  // Grants are suppressed while reset is asserted.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if_gnt = if_req & (~ls_req | starved);
      ls_gnt = ls_req & ~if_gnt;
    end
  end

  assign if_stall  = if_req & ~if_gnt;
  assign mem_en    = if_gnt | ls_gnt;
  assign mem_we    = (ls_gnt && ls_we) ? ls_be : 4'b0000;
  // Address and write data hold their last value on idle cycles.
  assign mem_addr  = if_gnt ? if_addr : (ls_gnt ? ls_addr : mem_addr_q);
  assign mem_wdata = ls_gnt ? ls_wdata : mem_wdata_q;

  // Next state: starvation counter and owner of next cycle's read data.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && !starved) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    resp_own_d = OWN_NONE;
    if (if_gnt) begin
      resp_own_d = OWN_FETCH;
    end else if (ls_gnt && !ls_we) begin
      resp_own_d = OWN_LSU;
    end
  end

  // Response demux; a redirect kills the fetch response arriving this cycle,
  // and reset drops any pending response immediately.
  always_comb begin
    if_rvalid = !rst && (resp_own_q == OWN_FETCH) && !if_flush;
    ls_rvalid = !rst && (resp_own_q == OWN_LSU);
    if_rdata  = (!rst && resp_own_q == OWN_FETCH) ? mem_rdata : if_rdata_q;
    ls_rdata  = (!rst && resp_own_q == OWN_LSU)   ? mem_rdata : ls_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      resp_own_q   <= OWN_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_own_q   <= resp_own_d;
      mem_addr_q   <= mem_addr;
      mem_wdata_q  <= mem_wdata;
      if (resp_own_q == OWN_FETCH) if_rdata_q <= mem_rdata;
      if (resp_own_q == OWN_LSU)   ls_rdata_q <= mem_rdata;
    end
  end

endmodule
